// File: rtl/ysyx_23060061_reg_writer.sv
// Register-file write-back stage: merges LSU/EXU results through a 2-entry FIFO
// and tracks outstanding destination writes in a per-register scoreboard.
module ysyx_23060061_reg_writer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  chk_hazard1,
  output logic                  chk_hazard2,
  output logic                  err
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] fifo_rd_q   [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];

  logic                  not_full;
  logic                  push_lsu, push_exu, push, pop;
  logic                  issue_fire;
  logic                  head_live;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] push_rd;
  logic [DATA_WIDTH-1:0] push_data;

  // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
  assign not_full  = (count_q < 2'd2);
  assign lsu_ready = not_full;
  assign exu_ready = not_full && !lsu_valid;

  assign push_lsu  = lsu_valid && lsu_ready;
  assign push_exu  = exu_valid && exu_ready;
  assign push      = push_lsu || push_exu;
  assign push_rd   = push_lsu ? lsu_rd   : exu_rd;
  assign push_data = push_lsu ? lsu_data : exu_data;

  assign pop       = (count_q != 2'd0);
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_live = pop && (head_rd != '0);

  assign rf_wen    = head_live;
  assign rf_waddr  = pop ? head_rd   : '0;
  assign rf_wdata  = pop ? head_data : '0;

  assign issue_ready = !pending_q[issue_rd] || (issue_rd == '0);
  assign issue_fire  = issue_valid && issue_ready;

  assign chk_hazard1 = pending_q[chk_addr1] || (pop && (head_rd == chk_addr1) && (chk_addr1 != '0));
  assign chk_hazard2 = pending_q[chk_addr2] || (pop && (head_rd == chk_addr2) && (chk_addr2 != '0));

  assign err = err_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Clear-then-set so a fresh reservation wins over a retiring write to the same index.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (head_live) begin
      if (!pending_q[head_rd]) err_d = 1'b1;
      pending_d[head_rd] = 1'b0;
    end
    if (issue_fire && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Payload storage carries no reset; validity is governed by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= push_rd;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_reg_writer.sv
// Directed bench for ysyx_23060061_reg_writer: hand-computed expectations
// for handshakes, write-back ordering, scoreboard hazards and error flag.
module tb_ysyx_23060061_reg_writer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_hazard1;
  logic        chk_hazard2;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_23060061_reg_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_hazard1 (chk_hazard1),
    .chk_hazard2 (chk_hazard2),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let new inputs settle before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    exu_valid   = 1'b0;
    lsu_valid   = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wen"},   {31'd0, rf_wen}, 32'd1);
    check({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    check({tag, "_wdata"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 0; issue_rd = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;

    // Reset state
    #2;
    check("rst_wen",       {31'd0, rf_wen}, 32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_exu_ready", {31'd0, exu_ready}, 32'd1);
    check("rst_issue_rdy", {31'd0, issue_ready}, 32'd1);
    check("rst_haz1",      {31'd0, chk_hazard1}, 32'd0);
    check("rst_haz2",      {31'd0, chk_hazard2}, 32'd0);
    check("rst_err",       {31'd0, err}, 32'd0);
    lsu_valid = 1'b1; settle();
    check("rst_exu_ready_lsu", {31'd0, exu_ready}, 32'd0);
    lsu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    // Issue rd 5, EXU result to 5
    issue_valid = 1; issue_rd = 5'd5; chk_addr1 = 5'd5; chk_addr2 = 5'd6; settle();
    check("t36_issue_rdy", {31'd0, issue_ready}, 32'd1);
    check("t36_haz_pre",   {31'd0, chk_hazard1}, 32'd0);
    step(); idle(); settle();
    check("t36_haz_pend",  {31'd0, chk_hazard1}, 32'd1);
    check("t36_haz2_other",{31'd0, chk_hazard2}, 32'd0);
    check("t36_wen_idle",  {31'd0, rf_wen}, 32'd0);
    exu_valid = 1; exu_rd = 5'd5; exu_data = 32'h1234; settle();
    check("t36_exu_ready", {31'd0, exu_ready}, 32'd1);
    step(); idle(); settle();
    check_write("t36", 5'd5, 32'h1234);
    check("t36_haz_head",  {31'd0, chk_hazard1}, 32'd1);
    step(); settle();
    check("t36_wen_after", {31'd0, rf_wen}, 32'd0);
    check("t36_haz_clear", {31'd0, chk_hazard1}, 32'd0);
    check("t36_err",       {31'd0, err}, 32'd0);

    // EXU and LSU both valid: LSU first
    issue_valid = 1; issue_rd = 5'd3; step();
    issue_rd = 5'd4; step(); idle();
    exu_valid = 1; exu_rd = 5'd3; exu_data = 32'hAAAA_0003;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004; settle();
    check("t37_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("t37_exu_block", {31'd0, exu_ready}, 32'd0);
    step(); lsu_valid = 0; settle();
    check_write("t37_first", 5'd4, 32'hBBBB_0004);
    check("t37_exu_ready", {31'd0, exu_ready}, 32'd1);
    step(); idle(); settle();
    check_write("t37_second", 5'd3, 32'hAAAA_0003);
    step(); settle();
    check("t37_wen_after", {31'd0, rf_wen}, 32'd0);
    check("t37_err",       {31'd0, err}, 32'd0);

    // Back-to-back EXU results with one LSU stall cycle
    issue_valid = 1; issue_rd = 5'd10; step();
    issue_rd = 5'd11; step();
    issue_rd = 5'd12; step();
    issue_rd = 5'd13; step(); idle();
    exu_valid = 1; exu_rd = 5'd10; exu_data = 32'hA0; step();
    exu_rd = 5'd11; exu_data = 32'hB0;
    lsu_valid = 1; lsu_rd = 5'd13; lsu_data = 32'hD0; settle();
    check("t38_exu_stall", {31'd0, exu_ready}, 32'd0);
    check_write("t38_w10", 5'd10, 32'hA0);
    step(); lsu_valid = 0; settle();
    check("t38_exu_resume", {31'd0, exu_ready}, 32'd1);
    check_write("t38_w13", 5'd13, 32'hD0);
    step(); exu_rd = 5'd12; exu_data = 32'hC0; settle();
    check_write("t38_w11", 5'd11, 32'hB0);
    step(); idle(); settle();
    check_write("t38_w12", 5'd12, 32'hC0);
    step(); settle();
    check("t38_wen_after", {31'd0, rf_wen}, 32'd0);
    check("t38_err",       {31'd0, err}, 32'd0);

    // WAW blocking on rd 7, and rd 0 never blocks
    issue_valid = 1; issue_rd = 5'd7; settle();
    check("t39_first_rdy", {31'd0, issue_ready}, 32'd1);
    step(); settle();
    check("t39_second_blk", {31'd0, issue_ready}, 32'd0);
    step();
    exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h77; settle();
    check("t39_still_blk", {31'd0, issue_ready}, 32'd0);
    step(); exu_valid = 0; settle();
    check_write("t39_w7", 5'd7, 32'h77);
    check("t39_blk_on_pop", {31'd0, issue_ready}, 32'd1 - 32'd1);
    step(); settle();
    check("t39_rdy_after", {31'd0, issue_ready}, 32'd1);
    step(); idle();
    exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h78; step(); idle(); step(); settle();
    check("t39_err_clean", {31'd0, err}, 32'd0);
    issue_valid = 1; issue_rd = 5'd0; chk_addr1 = 5'd0; settle();
    check("t39_rd0_rdy", {31'd0, issue_ready}, 32'd1);
    step(); settle();
    check("t39_rd0_rdy2", {31'd0, issue_ready}, 32'd1);
    check("t39_rd0_haz",  {31'd0, chk_hazard1}, 32'd0);
    idle();

    // Unissued write sets sticky err; rd 0 result is dropped
    exu_valid = 1; exu_rd = 5'd9; exu_data = 32'h99; step(); idle(); settle();
    check_write("t40_w9", 5'd9, 32'h99);
    check("t40_err_pre", {31'd0, err}, 32'd0);
    step(); settle();
    check("t40_err_set", {31'd0, err}, 32'd1);
    exu_valid = 1; exu_rd = 5'd0; exu_data = 32'h55; step(); idle(); settle();
    check("t40_rd0_wen", {31'd0, rf_wen}, 32'd0);
    step(); step(); settle();
    check("t40_err_sticky", {31'd0, err}, 32'd1);

    // Async reset mid-operation with an entry buffered
    issue_valid = 1; issue_rd = 5'd20; step(); idle();
    exu_valid = 1; exu_rd = 5'd20; exu_data = 32'h2020; step(); idle();
    chk_addr1 = 5'd20; issue_rd = 5'd20; settle();
    check("t41_wen_pre", {31'd0, rf_wen}, 32'd1);
    check("t41_haz_pre", {31'd0, chk_hazard1}, 32'd1);
    rst = 1'b0; #1;
    check("t41_wen_rst",   {31'd0, rf_wen}, 32'd0);
    check("t41_haz_rst",   {31'd0, chk_hazard1}, 32'd0);
    check("t41_issue_rst", {31'd0, issue_ready}, 32'd1);
    check("t41_err_rst",   {31'd0, err}, 32'd0);
    check("t41_lsu_rst",   {31'd0, lsu_ready}, 32'd1);
    #2 rst = 1'b1;
    step(); settle();
    check("t41_wen_post", {31'd0, rf_wen}, 32'd0);
    step(); settle();
    check("t41_wen_post2", {31'd0, rf_wen}, 32'd0);
    check("t41_err_post",  {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
